// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU load/store port. Accepts one
// word-granular request at a time over a valid/ready channel, performs the
// array access after WAIT_CYCLES wait states, then holds the result on a
// valid/ready response channel until the core takes it.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   req_valid   request present          req_ready   responder can accept
//   req_we      1 = store, 0 = load      req_addr    byte address
//   req_wdata   store data               req_be      store byte enables
//   resp_valid  response present         resp_ready  core accepts response
//   resp_rdata  load data (0 for stores and faults)
//   resp_err    access fault
//
// Optional feature: define DATA_MEM_MISALIGN_CHECK_EN to fault any request
// whose req_addr[1:0] is non-zero (in addition to the range check). When it
// is undefined, addr[1:0] is ignored and the containing word is accessed.

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam bit NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               cap_we;
   logic [31:0]        cap_addr;
   logic [31:0]        cap_wdata;
   logic [3:0]         cap_be;

   logic [31:0]        mem [DEPTH_WORDS];

   logic               acc_we_c;
   logic [31:0]        acc_addr_c;
   logic [31:0]        acc_wdata_c;
   logic [3:0]         acc_be_c;
   logic [31:0]        off_c;
   logic [IDX_W-1:0]   idx_c;
   logic               fault_c;
   logic               access_c;
   logic               wr_en_c;
   logic [31:0]        rd_data_c;

   // Access decode. With no wait states the access happens on the accept
   // edge, so the live request fields are used instead of the captured ones.
   always_comb begin
      acc_we_c    = NO_WAIT ? req_we    : cap_we;
      acc_addr_c  = NO_WAIT ? req_addr  : cap_addr;
      acc_wdata_c = NO_WAIT ? req_wdata : cap_wdata;
      acc_be_c    = NO_WAIT ? req_be    : cap_be;
      off_c       = acc_addr_c - BASE_ADDR;
      idx_c       = off_c[IDX_W+1:2];
      // Unsigned subtraction wraps, so addresses below BASE_ADDR land out of range.
      fault_c     = ({1'b0, off_c} >= SPAN);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      if (acc_addr_c[1:0] != 2'b00) begin
         fault_c = 1'b1;
      end
`endif
      access_c    = ((state == S_IDLE) && req_valid && NO_WAIT) ||
                    ((state == S_WAIT) && (cnt == '0));
      // Gate with rst so an access edge coinciding with reset never commits.
      wr_en_c     = rst && access_c && acc_we_c && !fault_c;
      rd_data_c   = (fault_c || acc_we_c) ? 32'h0 : mem[idx_c];
   end

   // Word array with per-byte write enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be_c[i]) begin
               mem[idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
            end
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         cap_we     <= 1'b0;
         cap_addr   <= 32'h0;
         cap_wdata  <= 32'h0;
         cap_be     <= 4'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cap_we    <= req_we;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  cap_be    <= req_be;
                  req_ready <= 1'b0;
                  if (NO_WAIT) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= rd_data_c;
                     resp_err   <= fault_c;
                  end else begin
                     cnt   <= CNT_INIT;
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rd_data_c;
                  resp_err   <= fault_c;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               // Return to IDLE only; a new request is taken on the next edge.
               if (resp_ready) begin
                  state      <= S_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'h0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule
